// File: rtl/stopwatch_digit_pair.sv
// rtl/stopwatch_digit_pair.sv - two-digit BCD up/down counter with cascaded wrap pulse
// Optional preset port group enabled by macro SW_LOAD_EN.
module stopwatch_digit_pair #(
    parameter int UNITS_MAX = 9,
    parameter int TENS_MAX  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       tick,
    input  logic       up,
    input  logic       clr,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       at_limit,
    output logic       wrap
`ifdef SW_LOAD_EN
    ,
    input  logic       load,
    input  logic [3:0] load_units,
    input  logic [3:0] load_tens
`endif
);

    localparam logic [3:0] UMAX = 4'(UNITS_MAX);
    localparam logic [3:0] TMAX = 4'(TENS_MAX);

    logic [3:0] units_nx;
    logic [3:0] tens_nx;
    logic       wrap_nx;
    logic       step;

    assign step = en & tick;

    // Terminal value depends on the direction currently presented.
    assign at_limit = up ? ((tens == TMAX) && (units == UMAX))
                         : ((tens == 4'd0) && (units == 4'd0));

`ifdef SW_LOAD_EN
    function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction
`endif

    always_comb begin
        units_nx = units;
        tens_nx  = tens;
        wrap_nx  = 1'b0;
        if (clr) begin
            units_nx = 4'd0;
            tens_nx  = 4'd0;
`ifdef SW_LOAD_EN
        end else if (load) begin
            units_nx = clamp(load_units, UMAX);
            tens_nx  = clamp(load_tens, TMAX);
`endif
        end else if (step) begin
            if (up) begin
                // Out-of-range digits count as already at max and roll over.
                if (units < UMAX) begin
                    units_nx = units + 4'd1;
                end else begin
                    units_nx = 4'd0;
                    if (tens < TMAX) begin
                        tens_nx = tens + 4'd1;
                    end else begin
                        tens_nx = 4'd0;
                        wrap_nx = 1'b1;
                    end
                end
            end else begin
                // Going down, an out-of-range digit is first pulled back to its max.
                if (units > UMAX) begin
                    units_nx = UMAX;
                end else if (units != 4'd0) begin
                    units_nx = units - 4'd1;
                end else begin
                    units_nx = UMAX;
                    if (tens > TMAX) begin
                        tens_nx = TMAX;
                    end else if (tens != 4'd0) begin
                        tens_nx = tens - 4'd1;
                    end else begin
                        tens_nx = TMAX;
                        wrap_nx = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            units <= 4'd0;
            tens  <= 4'd0;
            wrap  <= 1'b0;
        end else begin
            units <= units_nx;
            tens  <= tens_nx;
            wrap  <= wrap_nx;
        end
    end

endmodule
